// File: rtl/sc_config_regbank.sv
// Avalon-MM config/status register bank with staged config words committed on a frame strobe.
module sc_config_regbank #(
  parameter int unsigned NUM_STATUS = 3,
  parameter int unsigned NUM_CONFIG = 12,
  parameter int unsigned ADDR_W     = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [ADDR_W-1:0]         avalon_s_address,
  input  logic [31:0]               avalon_s_writedata,
  input  logic [3:0]                avalon_s_byteenable,
  input  logic                      avalon_s_write,
  input  logic                      avalon_s_read,
  input  logic                      avalon_s_chipselect,
  output logic [31:0]               avalon_s_readdata,
  output logic                      avalon_s_readdatavalid,
  output logic                      avalon_s_waitrequest_n,
  input  logic [32*NUM_STATUS-1:0]  status_i,
  input  logic                      update_strobe_i,
  output logic [32*NUM_CONFIG-1:0]  config_o,
  output logic                      config_update_o,
  output logic                      irq_o
);

  localparam int unsigned CFG_BASE  = NUM_STATUS;
  localparam int unsigned CFG_END   = NUM_STATUS + NUM_CONFIG;
  localparam int unsigned CTRL_ADDR = (32'd1 << ADDR_W) - 32'd1;

  // Reject maps where the config window would reach or overlap CTRL.
  generate
    if (NUM_STATUS < 1 || NUM_CONFIG < 1 || ADDR_W < 1 || ADDR_W > 16 || CFG_END > CTRL_ADDR) begin : g_param_check
      $error("sc_config_regbank: NUM_STATUS+NUM_CONFIG must be <= 2**ADDR_W-1");
    end
  endgenerate

  logic [31:0] staging_q     [NUM_CONFIG];
  logic [31:0] active_q      [NUM_CONFIG];
  logic [31:0] status_q      [NUM_STATUS];
  logic [31:0] status_prev_q [NUM_STATUS];
  logic        status_vld_q;
  logic        status_prev_vld_q;

  logic commit_pending_q;
  logic immediate_q;
  logic irq_en_q;
  logic status_chg_q;
  logic commit_done_q;

  logic [31:0]           addr_ext_c;
  logic                  wr_c;
  logic                  rd_c;
  logic                  ctrl_wr_c;
  logic [NUM_CONFIG-1:0] cfg_hit_c;
  logic                  cfg_wr_c;
  logic                  commit_fire_c;
  logic                  status_diff_c;
  logic [31:0]           rd_data_c;

  // Merge new write data into an existing word under the byte lane enables.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  assign addr_ext_c    = 32'(avalon_s_address);
  assign wr_c          = avalon_s_chipselect & avalon_s_write;
  assign rd_c          = avalon_s_chipselect & avalon_s_read;
  assign ctrl_wr_c     = wr_c & (addr_ext_c == 32'(CTRL_ADDR)) & avalon_s_byteenable[0];
  assign commit_fire_c = update_strobe_i & commit_pending_q;
  assign cfg_wr_c      = |cfg_hit_c;

  assign avalon_s_waitrequest_n = 1'b1;

  // Decode which config word (if any) the current write targets.
  always_comb begin
    cfg_hit_c = '0;
    for (int k = 0; k < int'(NUM_CONFIG); k++) begin
      cfg_hit_c[k] = wr_c & (addr_ext_c == (32'(CFG_BASE) + 32'(k)));
    end
  end

  // Detect any change between the last two valid status samples.
  always_comb begin
    status_diff_c = 1'b0;
    for (int k = 0; k < int'(NUM_STATUS); k++) begin
      if (status_q[k] != status_prev_q[k]) status_diff_c = 1'b1;
    end
  end

  // Read mux over status, staging and CTRL; unmapped addresses return 0.
  always_comb begin
    rd_data_c = '0;
    for (int k = 0; k < int'(NUM_STATUS); k++) begin
      if (addr_ext_c == 32'(k)) rd_data_c = status_q[k];
    end
    for (int k = 0; k < int'(NUM_CONFIG); k++) begin
      if (addr_ext_c == (32'(CFG_BASE) + 32'(k))) rd_data_c = staging_q[k];
    end
    if (addr_ext_c == 32'(CTRL_ADDR)) begin
      rd_data_c = {27'd0, commit_done_q, status_chg_q, irq_en_q, immediate_q, commit_pending_q};
    end
  end

  // Staging registers take byte-merged writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < int'(NUM_CONFIG); k++) staging_q[k] <= '0;
    end else begin
      for (int k = 0; k < int'(NUM_CONFIG); k++) begin
        if (cfg_hit_c[k]) staging_q[k] <= merge_bytes(staging_q[k], avalon_s_writedata, avalon_s_byteenable);
      end
    end
  end

  // Active registers: commit copies pre-write staging; an immediate write to a word overrides it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < int'(NUM_CONFIG); k++) active_q[k] <= '0;
    end else begin
      for (int k = 0; k < int'(NUM_CONFIG); k++) begin
        if (immediate_q && cfg_hit_c[k]) begin
          active_q[k] <= merge_bytes(staging_q[k], avalon_s_writedata, avalon_s_byteenable);
        end else if (commit_fire_c) begin
          active_q[k] <= staging_q[k];
        end
      end
    end
  end

  // Status sampling pipeline; comparison only once two real samples exist.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < int'(NUM_STATUS); k++) begin
        status_q[k]      <= '0;
        status_prev_q[k] <= '0;
      end
      status_vld_q      <= 1'b0;
      status_prev_vld_q <= 1'b0;
    end else begin
      for (int k = 0; k < int'(NUM_STATUS); k++) begin
        status_q[k]      <= status_i[32*k +: 32];
        status_prev_q[k] <= status_q[k];
      end
      status_vld_q      <= 1'b1;
      status_prev_vld_q <= status_vld_q;
    end
  end

  // CTRL bits, sticky flags, update pulse and interrupt; set events win over W1C.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      commit_pending_q <= 1'b0;
      immediate_q      <= 1'b0;
      irq_en_q         <= 1'b0;
      status_chg_q     <= 1'b0;
      commit_done_q    <= 1'b0;
      config_update_o  <= 1'b0;
      irq_o            <= 1'b0;
    end else begin
      commit_pending_q <= (commit_pending_q & ~commit_fire_c) | (ctrl_wr_c & avalon_s_writedata[0]);
      if (ctrl_wr_c) begin
        immediate_q <= avalon_s_writedata[1];
        irq_en_q    <= avalon_s_writedata[2];
      end
      status_chg_q    <= (status_prev_vld_q & status_diff_c) |
                         (status_chg_q & ~(ctrl_wr_c & avalon_s_writedata[3]));
      commit_done_q   <= commit_fire_c | (commit_done_q & ~(ctrl_wr_c & avalon_s_writedata[4]));
      config_update_o <= commit_fire_c | (immediate_q & cfg_wr_c);
      irq_o           <= irq_en_q & (status_chg_q | commit_done_q);
    end
  end

  // Registered read response with fixed one-cycle latency.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      avalon_s_readdata      <= '0;
      avalon_s_readdatavalid <= 1'b0;
    end else begin
      avalon_s_readdatavalid <= rd_c;
      avalon_s_readdata      <= rd_c ? rd_data_c : 32'd0;
    end
  end

  // Pack active words onto the config bus.
  generate
    for (genvar g = 0; g < int'(NUM_CONFIG); g++) begin : g_cfg_out
      assign config_o[32*g +: 32] = active_q[g];
    end
  endgenerate

endmodule

// File: tb/tb_sc_config_regbank.sv
// Self-checking bench for sc_config_regbank: directed scenarios plus randomized traffic vs a reference model.
module tb_sc_config_regbank;

  localparam int NS   = 3;
  localparam int NC   = 12;
  localparam int AW   = 5;
  localparam int CTRL = 31;
  localparam int CW   = 32 * NC;

  logic            clk_i;
  logic            rst_i;
  logic [AW-1:0]   avalon_s_address;
  logic [31:0]     avalon_s_writedata;
  logic [3:0]      avalon_s_byteenable;
  logic            avalon_s_write;
  logic            avalon_s_read;
  logic            avalon_s_chipselect;
  logic [31:0]     avalon_s_readdata;
  logic            avalon_s_readdatavalid;
  logic            avalon_s_waitrequest_n;
  logic [32*NS-1:0] status_i;
  logic            update_strobe_i;
  logic [CW-1:0]   config_o;
  logic            config_update_o;
  logic            irq_o;

  sc_config_regbank #(.NUM_STATUS(NS), .NUM_CONFIG(NC), .ADDR_W(AW)) dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .avalon_s_address       (avalon_s_address),
    .avalon_s_writedata     (avalon_s_writedata),
    .avalon_s_byteenable    (avalon_s_byteenable),
    .avalon_s_write         (avalon_s_write),
    .avalon_s_read          (avalon_s_read),
    .avalon_s_chipselect    (avalon_s_chipselect),
    .avalon_s_readdata      (avalon_s_readdata),
    .avalon_s_readdatavalid (avalon_s_readdatavalid),
    .avalon_s_waitrequest_n (avalon_s_waitrequest_n),
    .status_i               (status_i),
    .update_strobe_i        (update_strobe_i),
    .config_o               (config_o),
    .config_update_o        (config_update_o),
    .irq_o                  (irq_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Single comparison point: counts and reports mismatches.
  task automatic check_val(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state, kept as plain arrays and flags.
  logic [31:0] m_stg [NC];
  logic [31:0] m_act [NC];
  logic [31:0] m_sq [NS];
  logic [31:0] m_sq_old [NS];
  int          m_nsamp;
  logic        m_pend, m_imm, m_ien, m_chg, m_done;
  logic [31:0] e_rdata;
  logic        e_rvalid, e_upd, e_irq;

  function automatic logic [31:0] m_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (o & ~mask) | (n & mask);
  endfunction

  function automatic logic [31:0] m_read(input int a);
    if (a < NS) return m_sq[a];
    if (a < NS + NC) return m_stg[a - NS];
    if (a == CTRL) return {27'd0, m_done, m_chg, m_ien, m_imm, m_pend};
    return 32'd0;
  endfunction

  function automatic logic [CW-1:0] m_cfg_bus();
    logic [CW-1:0] v;
    for (int k = 0; k < NC; k++) v[32*k +: 32] = m_act[k];
    return v;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    logic fire, chg_set, ctrl_w, cfg_w;
    int a, idx;
    logic [31:0] mv;
    if (rst_i) begin
      for (int k = 0; k < NC; k++) begin m_stg[k] = '0; m_act[k] = '0; end
      for (int k = 0; k < NS; k++) begin m_sq[k] = '0; m_sq_old[k] = '0; end
      m_nsamp = 0;
      m_pend = 0; m_imm = 0; m_ien = 0; m_chg = 0; m_done = 0;
      e_rdata = '0; e_rvalid = 0; e_upd = 0; e_irq = 0;
      return;
    end
    a        = int'(avalon_s_address);
    e_rvalid = avalon_s_chipselect & avalon_s_read;
    e_rdata  = e_rvalid ? m_read(a) : 32'd0;
    e_irq    = m_ien & (m_chg | m_done);
    fire     = update_strobe_i & m_pend;
    chg_set  = 1'b0;
    if (m_nsamp >= 2) begin
      for (int k = 0; k < NS; k++) if (m_sq[k] != m_sq_old[k]) chg_set = 1'b1;
    end
    ctrl_w = avalon_s_chipselect & avalon_s_write & (a == CTRL) & avalon_s_byteenable[0];
    cfg_w  = avalon_s_chipselect & avalon_s_write & (a >= NS) & (a < NS + NC);
    if (fire) for (int k = 0; k < NC; k++) m_act[k] = m_stg[k];
    if (cfg_w) begin
      idx = a - NS;
      mv  = m_merge(m_stg[idx], avalon_s_writedata, avalon_s_byteenable);
      m_stg[idx] = mv;
      if (m_imm) m_act[idx] = mv;
    end
    e_upd  = fire | (cfg_w & m_imm);
    m_pend = (m_pend & ~fire) | (ctrl_w & avalon_s_writedata[0]);
    m_done = fire | (m_done & ~(ctrl_w & avalon_s_writedata[4]));
    m_chg  = chg_set | (m_chg & ~(ctrl_w & avalon_s_writedata[3]));
    if (ctrl_w) begin
      m_imm = avalon_s_writedata[1];
      m_ien = avalon_s_writedata[2];
    end
    for (int k = 0; k < NS; k++) begin
      m_sq_old[k] = m_sq[k];
      m_sq[k]     = status_i[32*k +: 32];
    end
    if (m_nsamp < 2) m_nsamp++;
  endtask

  task automatic check_outputs();
    check_val("readdata",      CW'(avalon_s_readdata),      CW'(e_rdata));
    check_val("readdatavalid", CW'(avalon_s_readdatavalid), CW'(e_rvalid));
    check_val("config_update", CW'(config_update_o),        CW'(e_upd));
    check_val("irq",           CW'(irq_o),                  CW'(e_irq));
    check_val("config_o",      config_o,                    m_cfg_bus());
  endtask

  task automatic cycle();
    @(posedge clk_i);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic bus_clear();
    avalon_s_chipselect = 0; avalon_s_write = 0; avalon_s_read = 0;
    avalon_s_address = '0; avalon_s_writedata = '0; avalon_s_byteenable = '0;
  endtask

  task automatic do_write(input int a, input logic [31:0] d, input logic [3:0] be);
    avalon_s_chipselect = 1; avalon_s_write = 1; avalon_s_read = 0;
    avalon_s_address = AW'(a); avalon_s_writedata = d; avalon_s_byteenable = be;
    cycle();
    bus_clear();
  endtask

  task automatic do_read(input int a, output logic [31:0] d);
    avalon_s_chipselect = 1; avalon_s_write = 0; avalon_s_read = 1;
    avalon_s_address = AW'(a); avalon_s_byteenable = 4'hF;
    cycle();
    d = avalon_s_readdata;
    bus_clear();
  endtask

  logic [31:0] rd;
  int          ra;

  initial begin
    rst_i = 1; update_strobe_i = 0; status_i = '0;
    bus_clear();

    // Reset, then read every mapped address.
    idle(2);
    rst_i = 0;
    cycle();
    for (int a = 0; a < NS + NC; a++) begin
      do_read(a, rd);
      check_val("reset_read", CW'(rd), CW'(32'd0));
    end
    do_read(CTRL, rd);
    check_val("reset_ctrl", CW'(rd), CW'(32'd0));
    cycle();
    check_val("rvalid_one_cycle", CW'(avalon_s_readdatavalid), CW'(1'b0));
    check_val("reset_cfg", config_o, CW'(0));
    check_val("reset_irq", CW'(irq_o), CW'(1'b0));

    // Staged write with partial byte enables.
    do_write(3, 32'hDEADBEEF, 4'b0101);
    do_read(3, rd);
    check_val("stage_readback", CW'(rd), CW'(32'h00AD00EF));
    check_val("stage_not_active", CW'(config_o[31:0]), CW'(32'd0));

    // Commit on strobe.
    do_write(CTRL, 32'h1, 4'hF);
    update_strobe_i = 1;
    cycle();
    update_strobe_i = 0;
    check_val("commit_pulse", CW'(config_update_o), CW'(1'b1));
    check_val("commit_word0", CW'(config_o[31:0]), CW'(32'h00AD00EF));
    cycle();
    check_val("commit_pulse_single", CW'(config_update_o), CW'(1'b0));
    do_read(CTRL, rd);
    check_val("ctrl_after_commit", CW'(rd), CW'(32'h10));

    // Staging write on the commit edge.
    do_write(3, 32'h5, 4'hF);
    do_write(CTRL, 32'h1, 4'hF);
    avalon_s_chipselect = 1; avalon_s_write = 1; avalon_s_address = AW'(3);
    avalon_s_writedata = 32'h1; avalon_s_byteenable = 4'hF; update_strobe_i = 1;
    cycle();
    bus_clear(); update_strobe_i = 0;
    check_val("collide_active", CW'(config_o[31:0]), CW'(32'h5));
    do_read(3, rd);
    check_val("collide_staged", CW'(rd), CW'(32'h1));

    // COMMIT written on a strobe edge waits for the next strobe.
    do_write(4, 32'hA, 4'hF);
    avalon_s_chipselect = 1; avalon_s_write = 1; avalon_s_address = AW'(CTRL);
    avalon_s_writedata = 32'h1; avalon_s_byteenable = 4'hF; update_strobe_i = 1;
    cycle();
    bus_clear(); update_strobe_i = 0;
    check_val("late_commit_none", CW'(config_update_o), CW'(1'b0));
    idle(2);
    check_val("late_commit_word1_hold", CW'(config_o[63:32]), CW'(32'd0));
    update_strobe_i = 1;
    cycle();
    update_strobe_i = 0;
    check_val("late_commit_word1", CW'(config_o[63:32]), CW'(32'hA));
    check_val("late_commit_pulse", CW'(config_update_o), CW'(1'b1));

    // Status change raises irq three cycles later.
    do_write(CTRL, 32'h1C, 4'hF);
    idle(2);
    check_val("irq_quiet", CW'(irq_o), CW'(1'b0));
    status_i[63:32] = 32'd7;
    idle(2);
    check_val("irq_not_yet", CW'(irq_o), CW'(1'b0));
    cycle();
    check_val("irq_rise", CW'(irq_o), CW'(1'b1));

    // W1C of STATUS_CHG drops irq.
    do_write(CTRL, 32'h0C, 4'hF);
    cycle();
    check_val("irq_fall", CW'(irq_o), CW'(1'b0));

    // W1C coinciding with a new status change: set wins.
    status_i[63:32] = 32'd3;
    cycle();
    do_write(CTRL, 32'h0C, 4'hF);
    do_read(CTRL, rd);
    check_val("w1c_vs_set", CW'(rd), CW'(32'h0C));

    // Immediate mode.
    do_write(CTRL, 32'h2, 4'hF);
    do_write(NS + NC - 1, 32'h12345678, 4'hF);
    check_val("imm_word", CW'(config_o[32*NC-1 -: 32]), CW'(32'h12345678));
    check_val("imm_pulse", CW'(config_update_o), CW'(1'b1));
    cycle();
    check_val("imm_pulse_end", CW'(config_update_o), CW'(1'b0));

    // Reset discards a pending commit.
    do_write(CTRL, 32'h1, 4'hF);
    rst_i = 1;
    cycle();
    rst_i = 0;
    update_strobe_i = 1;
    cycle();
    update_strobe_i = 0;
    check_val("rst_no_pulse", CW'(config_update_o), CW'(1'b0));
    check_val("rst_cfg_zero", config_o, CW'(0));
    do_read(CTRL, rd);
    check_val("rst_ctrl_zero", CW'(rd), CW'(32'd0));

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst_i               = ($urandom_range(0, 299) == 0);
      avalon_s_chipselect = ($urandom_range(0, 3) != 0);
      avalon_s_write      = 1'($urandom_range(0, 1));
      avalon_s_read       = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       ra = CTRL;
        1:       ra = int'($urandom_range(0, 31));
        default: ra = int'($urandom_range(0, NS + NC - 1));
      endcase
      avalon_s_address    = AW'(ra);
      avalon_s_writedata  = $urandom;
      if (ra == CTRL && $urandom_range(0, 3) != 0) avalon_s_writedata = avalon_s_writedata & 32'h1F;
      avalon_s_byteenable = 4'($urandom_range(0, 15));
      update_strobe_i     = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) status_i[32*$urandom_range(0, NS-1) +: 32] = $urandom;
      cycle();
    end
    rst_i = 0; update_strobe_i = 0;
    bus_clear();
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
